accumulate_sat: RTL and testbench

Multi-channel saturating accumulator with selectable arbitration. Accepts signed W-bit operands from N strobe/ready input channels, sums D operands per result into a two's-complement running total clamped to the W-bit signed range, then presents the total on a single strobe/ready result port. It sits between neuron-level producers (weighted products) and the activation stage, replacing single-shot fixed-priority accumulation with a configurable-depth, round-robin-capable block.

---
 rtl/accumulate_sat.sv | 194 +++++++++++++++++++
 tb/tb_accumulate_sat.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulate_sat.sv
// -----------------------------------------------------------------------------
// accumulate_sat
//
// Multi-channel saturating accumulator. N producer channels offer signed W-bit
// operands. An arbiter accepts at most one operand per cycle. D operands are
// summed into a running total that is clamped to the W-bit signed range after
// every step. The finished total is then offered on a single result port.
//
// Handshake (applies to both ports): a word moves on a rising clk edge where
// its *_stb and the matching *_rdy are both high. A producer may drop *_stb
// without a transfer. While a result is pending (res_stb high, res_rdy low),
// res_dat and res_sat hold stable.
//
// Parameters
//   N   : number of input channels (>= 1)
//   W   : operand / result width, signed two's complement (>= 2)
//   D   : operands accepted per result (>= 1)
//   ARB : 0 = fixed priority (lowest index wins), 1 = round-robin
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous reset, active low
//   arg_stb   : per-channel operand valid
//   arg_dat   : operands, channel n in bits [n*W +: W]
//   arg_rdy   : per-channel accept, one-hot or zero
//   res_stb   : result valid
//   res_dat   : saturated sum
//   res_sat   : at least one clamp occurred while forming this result
//   res_rdy   : result accept
//   dbg_state : FSM state for checkers (0 = collecting, 1 = holding result)
// -----------------------------------------------------------------------------
module accumulate_sat #(
   parameter int N   = 2,
   parameter int W   = 16,
   parameter int D   = 4,
   parameter int ARB = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     arg_stb,
   input  logic [N*W-1:0]   arg_dat,
   output logic [N-1:0]     arg_rdy,
   output logic             res_stb,
   output logic [W-1:0]     res_dat,
   output logic             res_sat,
   input  logic             res_rdy,
   output logic             dbg_state
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (D > 1) ? $clog2(D) : 1;

   localparam logic [PW-1:0] PTR_RST  = PW'(N - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
   localparam logic [PW:0]   N_EXT    = (PW + 1)'(N);
   localparam logic [W-1:0]  SAT_MAX  = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]  SAT_MIN  = {1'b1, {(W-1){1'b0}}};

   typedef enum logic {
      ST_ACC = 1'b0,
      ST_RES = 1'b1
   } state_t;

   state_t          state;
   logic [W-1:0]    acc;
   logic [CW-1:0]   cnt;
   logic            sat_flag;
   logic [PW-1:0]   ptr;

   // ---------------------------------------------------------------------------
   // Arbiter
   // Fixed priority scans from channel 0. Round-robin scans from the channel
   // after the last grant and wraps. With N <= 2^PW, ptr + i + 1 stays below
   // 2N, so a single conditional subtraction of N is enough for the wrap.
   // ---------------------------------------------------------------------------
   logic [N-1:0]    grant_oh;
   logic [PW-1:0]   grant_idx;
   logic            grant_vld;
   logic [PW:0]     cand_w;
   logic [PW-1:0]   cand;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      cand_w    = '0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         if (ARB == 1) begin
            cand_w = {1'b0, ptr} + (PW + 1)'(i) + (PW + 1)'(1);
            if (cand_w >= N_EXT) begin
               cand_w = cand_w - N_EXT;
            end
            cand = cand_w[PW-1:0];
         end else begin
            cand = PW'(i);
         end
         if (!grant_vld && arg_stb[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
      if (grant_vld) begin
         grant_oh[grant_idx] = 1'b1;
      end
   end

   // Grants are only offered while collecting and never while reset is held.
   assign arg_rdy = (rst && (state == ST_ACC)) ? grant_oh : '0;

   logic xfer;
   assign xfer = grant_vld && (state == ST_ACC);

   // ---------------------------------------------------------------------------
   // Operand select: AND-OR mux over the one-hot grant
   // ---------------------------------------------------------------------------
   logic [W-1:0] sel_dat;

   always_comb begin
      sel_dat = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_oh[i]) begin
            sel_dat = sel_dat | arg_dat[i*W +: W];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Saturating add
   // The two operands are sign-extended to W+1 bits. Overflow shows up as the
   // top two bits of the sum disagreeing. The extra sign bit then says which
   // rail to clamp to.
   // ---------------------------------------------------------------------------
   logic [W:0]   sum_ext;
   logic         clip;
   logic [W-1:0] sum_sat;

   assign sum_ext = {acc[W-1], acc} + {sel_dat[W-1], sel_dat};
   assign clip    = sum_ext[W] ^ sum_ext[W-1];
   assign sum_sat = clip ? (sum_ext[W] ? SAT_MIN : SAT_MAX) : sum_ext[W-1:0];

   // ---------------------------------------------------------------------------
   // Control / datapath state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_ACC;
         acc      <= '0;
         cnt      <= '0;
         sat_flag <= 1'b0;
         ptr      <= PTR_RST;
         res_stb  <= 1'b0;
         res_dat  <= '0;
         res_sat  <= 1'b0;
      end else begin
         case (state)
            ST_ACC: begin
               if (xfer) begin
                  acc      <= sum_sat;
                  sat_flag <= sat_flag | clip;
                  ptr      <= grant_idx;
                  if (cnt == CNT_LAST) begin
                     // The result carries this step's clamp as well as the
                     // sticky history, because sat_flag only updates at this edge.
                     res_dat <= sum_sat;
                     res_sat <= sat_flag | clip;
                     res_stb <= 1'b1;
                     state   <= ST_RES;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            ST_RES: begin
               // No operand is taken in the release cycle, because arg_rdy is
               // low in ST_RES.
               if (res_rdy) begin
                  res_stb  <= 1'b0;
                  acc      <= '0;
                  cnt      <= '0;
                  sat_flag <= 1'b0;
                  state    <= ST_ACC;
               end
            end
            default: begin
               state <= ST_ACC;
            end
         endcase
      end
   end

   assign dbg_state = (state == ST_RES);

endmodule

// File: tb/tb_accumulate_sat.sv
// -----------------------------------------------------------------------------
// tb_accumulate_sat
//
// Bench for accumulate_sat. It drives three instances:
//   u_main : N=2, W=16, D=4, fixed priority
//   u_fp   : N=4, W=16, D=8, fixed priority
//   u_rr   : N=4, W=16, D=8, round-robin
//
// For u_main, a reference model computes each expected result as its operands
// are driven and pushes it onto exp_q. A monitor pops an entry each time
// res_stb rises.
// -----------------------------------------------------------------------------
module tb_accumulate_sat;

   localparam int W  = 16;
   localparam int N  = 2;
   localparam int D  = 4;
   localparam int AN = 4;
   localparam int AD = 8;

   // --------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // --------------------------------------------------------------- DUT signals
   logic [N-1:0]    m_arg_stb;
   logic [N*W-1:0]  m_arg_dat;
   logic [N-1:0]    m_arg_rdy;
   logic            m_res_stb;
   logic [W-1:0]    m_res_dat;
   logic            m_res_sat;
   logic            m_res_rdy;
   logic            m_dbg;

   logic [AN-1:0]   a_arg_stb;
   logic [AN*W-1:0] a_arg_dat;
   logic            a_res_rdy;
   logic [AN-1:0]   fp_arg_rdy, rr_arg_rdy;
   logic            fp_res_stb, rr_res_stb;
   logic [W-1:0]    fp_res_dat, rr_res_dat;
   logic            fp_res_sat, rr_res_sat;
   logic            fp_dbg, rr_dbg;

   accumulate_sat #(.N(N), .W(W), .D(D), .ARB(0)) u_main (
      .clk(clk), .rst(rst),
      .arg_stb(m_arg_stb), .arg_dat(m_arg_dat), .arg_rdy(m_arg_rdy),
      .res_stb(m_res_stb), .res_dat(m_res_dat), .res_sat(m_res_sat),
      .res_rdy(m_res_rdy), .dbg_state(m_dbg)
   );

   accumulate_sat #(.N(AN), .W(W), .D(AD), .ARB(0)) u_fp (
      .clk(clk), .rst(rst),
      .arg_stb(a_arg_stb), .arg_dat(a_arg_dat), .arg_rdy(fp_arg_rdy),
      .res_stb(fp_res_stb), .res_dat(fp_res_dat), .res_sat(fp_res_sat),
      .res_rdy(a_res_rdy), .dbg_state(fp_dbg)
   );

   accumulate_sat #(.N(AN), .W(W), .D(AD), .ARB(1)) u_rr (
      .clk(clk), .rst(rst),
      .arg_stb(a_arg_stb), .arg_dat(a_arg_dat), .arg_rdy(rr_arg_rdy),
      .res_stb(rr_res_stb), .res_dat(rr_res_dat), .res_sat(rr_res_sat),
      .res_rdy(a_res_rdy), .dbg_state(rr_dbg)
   );

   // --------------------------------------------------------------- checking
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // --------------------------------------------------------------- model + scoreboard
   logic [W:0] exp_q[$];        // {sat, dat}
   logic [W:0] last_exp = '0;
   int         mdl_acc  = 0;
   int         mdl_cnt  = 0;
   bit         mdl_sat  = 1'b0;

   task automatic model_clear();
      mdl_acc = 0;
      mdl_cnt = 0;
      mdl_sat = 1'b0;
   endtask

   task automatic model_step(input logic [W-1:0] v);
      int s;
      s = mdl_acc + int'($signed(v));
      if (s > 32767) begin
         s = 32767;
         mdl_sat = 1'b1;
      end else if (s < -32768) begin
         s = -32768;
         mdl_sat = 1'b1;
      end
      mdl_acc = s;
      mdl_cnt++;
      if (mdl_cnt == D) begin
         last_exp = {mdl_sat, W'(mdl_acc)};
         exp_q.push_back(last_exp);
      end
   endtask

   logic       stb_prev = 1'b0;
   logic [W:0] mon_e;

   always @(negedge clk) begin
      if (m_res_stb && !stb_prev) begin
         check("res_pending", exp_q.size(), 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("res_dat", m_res_dat, mon_e[W-1:0]);
            check("res_sat", m_res_sat, mon_e[W]);
         end
      end
      stb_prev = m_res_stb;
   end

   // --------------------------------------------------------------- drivers
   // Offers one operand on channel ch. Call it just after a rising edge.
   // It returns just after the edge on which the operand transferred.
   task automatic drive_op(input int ch, input logic [W-1:0] v);
      int waited;
      bit done;
      waited = 0;
      done   = 1'b0;
      m_arg_dat[ch*W +: W] = v;
      m_arg_stb[ch] = 1'b1;
      while (!done && waited < 20) begin
         @(negedge clk);
         if (m_arg_rdy[ch]) begin
            check("grant_onehot", m_arg_rdy, 32'd1 << ch);
            done = 1'b1;
         end else begin
            waited++;
         end
      end
      if (!done) begin
         check("grant_timeout", m_arg_rdy[ch], 1);
      end
      @(posedge clk);
      #1;
      m_arg_stb[ch] = 1'b0;
      if (done) begin
         model_step(v);
         check("res_latency", m_res_stb, (mdl_cnt == D));
         if (mdl_cnt == D) begin
            check("dbg_res", m_dbg, 1);
            model_clear();
         end
      end
   endtask

   // Keeps res_rdy low for hold cycles, with every channel requesting, and then
   // accepts the result.
   task automatic take_result(input int hold);
      m_arg_stb = '1;
      repeat (hold) begin
         @(negedge clk);
         check("hold_stb", m_res_stb, 1);
         check("hold_dat", m_res_dat, last_exp[W-1:0]);
         check("hold_sat", m_res_sat, last_exp[W]);
         check("hold_rdy", m_arg_rdy, 0);
      end
      m_arg_stb = '0;
      m_res_rdy = 1'b1;
      @(posedge clk);
      #1;
      m_res_rdy = 1'b0;
      check("release_stb", m_res_stb, 0);
      check("release_dbg", m_dbg, 0);
   endtask

   // --------------------------------------------------------------- stimulus
   int fp_cnt, fp_sum, rr_cnt, rr_sum, rr_ptr, exp_ch;

   initial begin
      m_arg_stb = '1;
      m_arg_dat = {16'd7, 16'd9};
      m_res_rdy = 1'b0;
      a_arg_stb = '1;
      a_arg_dat = {16'd4, 16'd3, 16'd2, 16'd1};
      a_res_rdy = 1'b1;

      // Reset with every channel requesting.
      #1 rst = 1'b0;
      #2;
      check("rst_rdy", m_arg_rdy, 0);
      check("rst_stb", m_res_stb, 0);
      check("rst_dat", m_res_dat, 0);
      check("rst_sat", m_res_sat, 0);
      check("rst_fp_rdy", fp_arg_rdy, 0);
      check("rst_rr_rdy", rr_arg_rdy, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_rdy_clk", m_arg_rdy, 0);
      check("rst_stb_clk", m_res_stb, 0);
      rst = 1'b1;
      #1;
      check("rel_rdy", m_arg_rdy, 2'b01);
      check("rel_fp_rdy", fp_arg_rdy, 4'b0001);
      check("rel_rr_rdy", rr_arg_rdy, 4'b0001);
      m_arg_stb = '0;
      a_arg_stb = '0;
      @(posedge clk);
      #1;

      // Basic sum, with backpressure held for 5 cycles.
      drive_op(0, 16'd10);
      drive_op(0, 16'hFFFD);
      drive_op(0, 16'd7);
      drive_op(0, 16'd100);
      check("basic_114", m_res_dat, 114);
      take_result(5);

      // Positive saturation at step 2.
      drive_op(1, 16'd30000);
      drive_op(0, 16'd30000);
      drive_op(1, 16'hEC78);   // -5000
      drive_op(0, 16'd1);
      check("pos_sat_dat", m_res_dat, 27768);
      take_result(0);

      // Negative saturation.
      drive_op(0, 16'h8000);
      drive_op(1, 16'hFFFF);
      drive_op(0, 16'd0);
      drive_op(1, 16'd0);
      check("neg_sat_dat", m_res_dat, 16'h8000);
      take_result(1);

      // Channel 1 requests while channel 0 wins, then drops without a transfer.
      m_arg_dat[W +: W] = 16'd999;
      m_arg_stb[1] = 1'b1;
      drive_op(0, 16'd50);
      m_arg_stb[1] = 1'b0;
      drive_op(1, 16'hFFC4);   // -60
      drive_op(0, 16'd3);
      drive_op(1, 16'd4);
      take_result(0);

      // Random operands, channels and gaps.
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < D; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            drive_op(int'($urandom_range(0, N - 1)), W'($urandom_range(0, 65535)));
         end
         take_result(int'($urandom_range(0, 3)));
      end

      // Asynchronous reset after 2 of 4 transfers.
      drive_op(0, 16'd1000);
      drive_op(1, 16'd2000);
      m_arg_stb[0] = 1'b1;
      #3 rst = 1'b0;
      #1;
      check("mid_rst_rdy", m_arg_rdy, 0);
      check("mid_rst_stb", m_res_stb, 0);
      check("mid_rst_dbg", m_dbg, 0);
      model_clear();
      @(posedge clk);
      #1;
      m_arg_stb = '0;
      rst = 1'b1;
      repeat (D) drive_op(0, 16'd1);
      check("after_rst_4", m_res_dat, 4);
      take_result(0);

      // Asynchronous reset while a result is pending.
      drive_op(0, 16'd5);
      drive_op(0, 16'd6);
      drive_op(1, 16'd7);
      drive_op(1, 16'd8);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("res_rst_stb", m_res_stb, 0);
      check("res_rst_dat", m_res_dat, 0);
      check("res_rst_sat", m_res_sat, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (D) drive_op(1, 16'd1);
      check("after_res_rst_4", m_res_dat, 4);
      take_result(0);

      // Arbitration: all 4 channels request continuously. Operands are 1,2,3,4.
      fp_cnt = 0;
      fp_sum = 0;
      rr_cnt = 0;
      rr_sum = 0;
      rr_ptr = AN - 1;
      a_arg_stb = '1;
      for (int c = 0; c < 2 * (AD + 1) + 2; c++) begin
         @(negedge clk);
         if (fp_cnt == AD) begin
            check("fp_res_stb", fp_res_stb, 1);
            check("fp_res_dat", fp_res_dat, fp_sum);
            check("fp_res_sat", fp_res_sat, 0);
            check("fp_res_rdy", fp_arg_rdy, 0);
            fp_cnt = 0;
            fp_sum = 0;
         end else begin
            check("fp_grant", fp_arg_rdy, 4'b0001);
            check("fp_idle_stb", fp_res_stb, 0);
            fp_cnt++;
            fp_sum += 1;
         end
         if (rr_cnt == AD) begin
            check("rr_res_stb", rr_res_stb, 1);
            check("rr_res_dat", rr_res_dat, rr_sum);
            check("rr_res_sat", rr_res_sat, 0);
            check("rr_res_rdy", rr_arg_rdy, 0);
            check("rr_dbg", rr_dbg, 1);
            rr_cnt = 0;
            rr_sum = 0;
         end else begin
            exp_ch = (rr_ptr + 1) % AN;
            check("rr_grant", rr_arg_rdy, 32'd1 << exp_ch);
            check("rr_idle_stb", rr_res_stb, 0);
            rr_ptr = exp_ch;
            rr_sum += exp_ch + 1;
            rr_cnt++;
         end
      end
      a_arg_stb = '0;
      check("fp_dbg_end", fp_dbg, 0);

      @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
